mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 134 +++++++++++++
 tb/tb_mac_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Sequences operand pairs into an external 2-cycle-latency MAC and returns the accumulated result.
// Optional overflow flag (res_ovf) is enabled by defining MAC_SEQ_OVF_EN.
module mac_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      len,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_a,
  input  logic [DATA_WIDTH-1:0]     in_b,
  output logic                      mac_reset,
  output logic [DATA_WIDTH-1:0]     mac_operand_a,
  output logic [DATA_WIDTH-1:0]     mac_operand_b,
  input  logic [2*DATA_WIDTH-1:0]   mac_acc,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*DATA_WIDTH-1:0]   res_data,
`ifdef MAC_SEQ_OVF_EN
  output logic                      res_ovf,
`endif
  output logic [2:0]                fsm_state
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
  // valid-side data is held stable until that edge.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic [1:0]           drain_cnt;
  logic                 accept;

  assign in_ready  = (state == FEED) && (cnt < len_q);
  assign accept    = in_valid && in_ready;
  assign mac_reset = reset || (state == CLEAR);
  assign fsm_state = state;

`ifdef MAC_SEQ_OVF_EN
  localparam int SW = 2*DATA_WIDTH + LEN_WIDTH;
  logic [SW-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      res_ovf <= 1'b0;
    end else begin
      if (state == CLEAR)
        shadow <= '0;
      else if (accept)
        shadow <= shadow + (SW'(in_a) * SW'(in_b));
      // Any bit above the MAC result width means the MAC result has wrapped.
      if (state == DRAIN && drain_cnt == 2'd2)
        res_ovf <= |shadow[SW-1:2*DATA_WIDTH];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      len_q         <= '0;
      cnt           <= '0;
      drain_cnt     <= '0;
      mac_operand_a <= '0;
      mac_operand_b <= '0;
      res_data      <= '0;
      res_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // Zero operands on non-accepting edges so the MAC adds nothing during bubbles.
      mac_operand_a <= accept ? in_a : '0;
      mac_operand_b <= accept ? in_b : '0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            len_q <= len;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          drain_cnt <= '0;
          state     <= (len_q != '0) ? FEED : DRAIN;
        end
        FEED: begin
          if (accept) begin
            cnt <= cnt + LEN_WIDTH'(1);
            if (cnt + LEN_WIDTH'(1) == len_q) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          // Third edge after the last accept: the MAC pipeline has settled.
          if (drain_cnt == 2'd2) begin
            state     <= DONE;
            res_data  <= mac_acc;
            res_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural 2-cycle MAC and a result scoreboard.
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, res_ready;
  logic [3:0] len, in_a, in_b;
  logic       busy, in_ready, mac_reset, res_valid;
  logic [3:0] mac_operand_a, mac_operand_b;
  logic [7:0] mac_acc, res_data;
  logic [2:0] fsm_state;
`ifdef MAC_SEQ_OVF_EN
  logic       res_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [3:0] pa[8];
  logic [3:0] pb[8];

  mac_sequencer #(.DATA_WIDTH(4), .LEN_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_reset(mac_reset), .mac_operand_a(mac_operand_a), .mac_operand_b(mac_operand_b),
    .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef MAC_SEQ_OVF_EN
    .res_ovf(res_ovf),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // MAC model: product stage then accumulate stage, cleared by mac_reset.
  logic [7:0] prod;
  always @(posedge clk) begin
    if (mac_reset) begin
      prod    <= '0;
      mac_acc <= '0;
    end else begin
      prod    <= 8'(mac_operand_a) * 8'(mac_operand_b);
      mac_acc <= mac_acc + prod;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: a result transfers on the next edge when valid and ready are both high
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0)
        check_val("unexpected_result", 32'(res_valid), 32'd0);
      else
        check_val("res_data", 32'(res_data), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      while (!in_ready && w < 20) begin
        tick();
        w++;
      end
      check_val("ready_timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check_val("op_a_load", 32'(mac_operand_a), 32'(pa[i]));
      check_val("op_b_load", 32'(mac_operand_b), 32'(pb[i]));
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check_val("op_a_gap", 32'(mac_operand_a), 32'd0);
          check_val("op_b_gap", 32'(mac_operand_b), 32'd0);
        end
      end
    end
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int c = 0;
    while (!res_valid && c < 20) begin
      tick();
      c++;
    end
    check_val(tag, 32'(c), 32'(exp_cyc));
  endtask

  task automatic finish_idle();
    tick();
    check_val("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b1;
    tick();
    tick();
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_res_data", 32'(res_data), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_mac_reset", 32'(mac_reset), 32'd1);
    check_val("rst_op_a", 32'(mac_operand_a), 32'd0);
    reset = 1'b0;
    tick();
    check_val("idle_mac_reset", 32'(mac_reset), 32'd0);

    // len=3 back-to-back: 2*3+4*5+1*7 = 33
    pa = '{4'd2, 4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    pb = '{4'd3, 4'd5, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    exp_q.push_back(8'd33);
    start_job(4'd3);
    check_val("clear_state", 32'(fsm_state), 32'd1);
    check_val("clear_mac_reset", 32'(mac_reset), 32'd1);
    check_val("clear_busy", 32'(busy), 32'd1);
    feed(3, 0);
    check_val("in_ready_after_last", 32'(in_ready), 32'd0);
    wait_done("latency_b2b", 3);
    finish_idle();

    // same pairs with 2-cycle gaps
    exp_q.push_back(8'd33);
    start_job(4'd3);
    feed(3, 2);
    wait_done("latency_gap", 3);
    finish_idle();

    // len=0: CLEAR, 3 DRAIN cycles, result 0 on the 4th cycle after start edge
    exp_q.push_back(8'd0);
    start_job(4'd0);
    wait_done("latency_len0", 4);
    finish_idle();

    // wrap: 225+225 = 450 mod 256 = 194
    pa[0] = 4'd15; pb[0] = 4'd15; pa[1] = 4'd15; pb[1] = 4'd15;
    exp_q.push_back(8'd194);
    start_job(4'd2);
    feed(2, 0);
    wait_done("latency_wrap", 3);
`ifdef MAC_SEQ_OVF_EN
    check_val("ovf_set", 32'(res_ovf), 32'd1);
`endif
    finish_idle();

    exp_q.push_back(8'd225);
    start_job(4'd1);
    feed(1, 0);
    wait_done("latency_225", 3);
`ifdef MAC_SEQ_OVF_EN
    check_val("ovf_clear", 32'(res_ovf), 32'd0);
`endif
    finish_idle();

    // backpressure in DONE with start pulsed: 1*2 = 2
    pa[0] = 4'd1; pb[0] = 4'd2;
    res_ready = 1'b0;
    start_job(4'd1);
    feed(1, 0);
    wait_done("latency_bp", 3);
    start = 1'b1;
    len   = 4'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_res_data", 32'(res_data), 32'd2);
      check_val("bp_res_valid", 32'(res_valid), 32'd1);
      check_val("bp_state", 32'(fsm_state), 32'd4);
    end
    start = 1'b0;
    exp_q.push_back(8'd2);
    res_ready = 1'b1;
    tick();
    check_val("bp_to_idle", 32'(fsm_state), 32'd0);
    check_val("bp_busy", 32'(busy), 32'd0);

    // abort mid-job by reset, then a fresh 3*3 job
    pa[0] = 4'd5; pb[0] = 4'd6;
    start_job(4'd3);
    feed(1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_state", 32'(fsm_state), 32'd0);
    check_val("abort_op_a", 32'(mac_operand_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("abort_res_valid", 32'(res_valid), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
    end
    pa[0] = 4'd3; pb[0] = 4'd3;
    exp_q.push_back(8'd9);
    start_job(4'd1);
    feed(1, 0);
    wait_done("latency_after_abort", 3);
    finish_idle();

    tick();
    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
